hilo_regfile: RTL and testbench

//  Architectural HI/LO register pair: the receiving end of the ALU's hi/lo result

---
 rtl/hilo_regfile.sv | 98 +++++++++
 tb/tb_hilo_regfile.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_regfile.sv
// HI/LO architectural register pair with M/W write slots that commit at W.
// Define HILO_FWD_EN to forward in-flight writes; otherwise reads raise stall_req.
module hilo_regfile #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          flush_e,
  input  logic          flush_m,
  input  logic [1:0]    hilo_we_e,
  input  logic [DW-1:0] hi_e,
  input  logic [DW-1:0] lo_e,
  input  logic [1:0]    rd_e,
  output logic [DW-1:0] hi_o,
  output logic [DW-1:0] lo_o,
  output logic          stall_req
);

  logic [DW-1:0] r_arch_hi;
  logic [DW-1:0] r_arch_lo;
  logic [1:0]    r_m_we;
  logic [DW-1:0] r_m_hi;
  logic [DW-1:0] r_m_lo;
  logic [1:0]    r_w_we;
  logic [DW-1:0] r_w_hi;
  logic [DW-1:0] r_w_lo;

  // Pipeline slots and architectural commit; flush_m kills M even while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_arch_hi <= {DW{1'b0}};
      r_arch_lo <= {DW{1'b0}};
      r_m_we    <= 2'b00;
      r_m_hi    <= {DW{1'b0}};
      r_m_lo    <= {DW{1'b0}};
      r_w_we    <= 2'b00;
      r_w_hi    <= {DW{1'b0}};
      r_w_lo    <= {DW{1'b0}};
    end else if (stall) begin
      if (flush_m) begin
        r_m_we <= 2'b00;
      end else begin
        r_m_we <= r_m_we;
      end
    end else begin
      if (r_w_we[1]) begin
        r_arch_hi <= r_w_hi;
      end
      if (r_w_we[0]) begin
        r_arch_lo <= r_w_lo;
      end
      r_w_we <= flush_m ? 2'b00 : r_m_we;
      r_w_hi <= r_m_hi;
      r_w_lo <= r_m_lo;
      r_m_we <= flush_e ? 2'b00 : hilo_we_e;
      r_m_hi <= hi_e;
      r_m_lo <= lo_e;
    end
  end

`ifdef HILO_FWD_EN
  logic [1:0] w_unused;
  assign w_unused = rd_e;

  // Newest-first operand select, each half on its own enable bit.
  always_comb begin
    if (r_m_we[1]) begin
      hi_o = r_m_hi;
    end else if (r_w_we[1]) begin
      hi_o = r_w_hi;
    end else begin
      hi_o = r_arch_hi;
    end
    if (r_m_we[0]) begin
      lo_o = r_m_lo;
    end else if (r_w_we[0]) begin
      lo_o = r_w_lo;
    end else begin
      lo_o = r_arch_lo;
    end
    stall_req = 1'b0;
  end
`else
  logic w_hi_busy;
  logic w_lo_busy;
  assign w_hi_busy = r_m_we[1] | r_w_we[1];
  assign w_lo_busy = r_m_we[0] | r_w_we[0];

  // Architectural-only reads; a read of a half with a write in flight must wait.
  always_comb begin
    hi_o      = r_arch_hi;
    lo_o      = r_arch_lo;
    stall_req = (rd_e[1] & w_hi_busy) | (rd_e[0] & w_lo_busy);
  end
`endif

endmodule

// File: tb/tb_hilo_regfile.sv
// Self-checking bench for hilo_regfile: per-scenario step tables, expected
// outputs queued at drive time and compared after each clock edge.
module tb_hilo_regfile;

`ifdef HILO_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        flush_e = 1'b0;
  logic        flush_m = 1'b0;
  logic [1:0]  hilo_we_e = 2'b00;
  logic [31:0] hi_e = 32'h0;
  logic [31:0] lo_e = 32'h0;
  logic [1:0]  rd_e = 2'b00;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        stall_req;

  hilo_regfile #(.DW(32)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush_e(flush_e), .flush_m(flush_m),
    .hilo_we_e(hilo_we_e), .hi_e(hi_e), .lo_e(lo_e), .rd_e(rd_e),
    .hi_o(hi_o), .lo_o(lo_o), .stall_req(stall_req)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r, s, fe, fm;
    logic [1:0]  we;
    logic [31:0] hi, lo;
    logic [1:0]  rd;
    logic [31:0] ehi, elo;
    logic        esr;
  } step_t;

  typedef struct {
    string       name;
    int          idx;
    logic [31:0] hi, lo;
    logic        sr;
  } exp_t;

  exp_t  sb_q[$];
  exp_t  ex;
  step_t st[$];
  int    n_checks = 0;
  int    n_pass = 0;
  int    n_fail = 0;

  function automatic step_t mk(input logic r, input logic s, input logic fe, input logic fm,
                               input logic [1:0] we, input logic [31:0] hi, input logic [31:0] lo,
                               input logic [1:0] rd, input logic [31:0] ehi, input logic [31:0] elo,
                               input logic esr);
    step_t t;
    t.r = r; t.s = s; t.fe = fe; t.fm = fm; t.we = we; t.hi = hi; t.lo = lo;
    t.rd = rd; t.ehi = ehi; t.elo = elo; t.esr = esr;
    return t;
  endfunction

  task automatic apply(input step_t t);
    rst = t.r; stall = t.s; flush_e = t.fe; flush_m = t.fm;
    hilo_we_e = t.we; hi_e = t.hi; lo_e = t.lo; rd_e = t.rd;
  endtask

  task automatic test_reset();
    st.delete();
    st.push_back(mk(1, 0, 0, 0, 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00, 32'h0, 32'h0, 1'b0));
    st.push_back(mk(1, 0, 0, 0, 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00, 32'h0, 32'h0, 1'b0));
    st.push_back(mk(0, 0, 0, 0, 2'b00, 32'h0, 32'h0, 2'b11, 32'h0, 32'h0, 1'b0));
    for (int i = 0; i < st.size(); i++) begin
      apply(st[i]);
      sb_q.push_back('{"reset", i, st[i].ehi, st[i].elo, st[i].esr});
      @(posedge clk); #1;
      ex = sb_q.pop_front();
      n_checks++;
      if ({hi_o, lo_o, stall_req} !== {ex.hi, ex.lo, ex.sr}) begin
        n_fail++;
        $display("FAIL %s step %0d: got hi=%h lo=%h sr=%b, want hi=%h lo=%h sr=%b",
                 ex.name, ex.idx, hi_o, lo_o, stall_req, ex.hi, ex.lo, ex.sr);
      end else n_pass++;
    end
  endtask

  task automatic test_mult_commit();
    st.delete();
    st.push_back(mk(0, 0, 0, 0, 2'b11, 32'h12345678, 32'h9ABCDEF0, 2'b00,
                    FWD ? 32'h12345678 : 32'h0, FWD ? 32'h9ABCDEF0 : 32'h0, 1'b0));
    st.push_back(mk(0, 0, 0, 0, 2'b00, 32'h0, 32'h0, 2'b11,
                    FWD ? 32'h12345678 : 32'h0, FWD ? 32'h9ABCDEF0 : 32'h0, !FWD));
    st.push_back(mk(0, 0, 0, 0, 2'b00, 32'h0, 32'h0, 2'b11, 32'h12345678, 32'h9ABCDEF0, 1'b0));
    for (int i = 0; i < st.size(); i++) begin
      apply(st[i]);
      sb_q.push_back('{"mult", i, st[i].ehi, st[i].elo, st[i].esr});
      @(posedge clk); #1;
      ex = sb_q.pop_front();
      n_checks++;
      if ({hi_o, lo_o, stall_req} !== {ex.hi, ex.lo, ex.sr}) begin
        n_fail++;
        $display("FAIL %s step %0d: got hi=%h lo=%h sr=%b, want hi=%h lo=%h sr=%b",
                 ex.name, ex.idx, hi_o, lo_o, stall_req, ex.hi, ex.lo, ex.sr);
      end else n_pass++;
    end
  endtask

  task automatic test_partial();
    st.delete();
    st.push_back(mk(0, 0, 0, 0, 2'b01, 32'hFFFFFFFF, 32'hAAAA5555, 2'b00,
                    32'h12345678, FWD ? 32'hAAAA5555 : 32'h9ABCDEF0, 1'b0));
    st.push_back(mk(0, 0, 0, 0, 2'b10, 32'hDEADBEEF, 32'h0BAD0BAD, 2'b01,
                    FWD ? 32'hDEADBEEF : 32'h12345678, FWD ? 32'hAAAA5555 : 32'h9ABCDEF0, !FWD));
    st.push_back(mk(0, 0, 0, 0, 2'b00, 32'h0, 32'h0, 2'b01,
                    FWD ? 32'hDEADBEEF : 32'h12345678, 32'hAAAA5555, 1'b0));
    st.push_back(mk(0, 0, 0, 0, 2'b00, 32'h0, 32'h0, 2'b00, 32'hDEADBEEF, 32'hAAAA5555, 1'b0));
    for (int i = 0; i < st.size(); i++) begin
      apply(st[i]);
      sb_q.push_back('{"partial", i, st[i].ehi, st[i].elo, st[i].esr});
      @(posedge clk); #1;
      ex = sb_q.pop_front();
      n_checks++;
      if ({hi_o, lo_o, stall_req} !== {ex.hi, ex.lo, ex.sr}) begin
        n_fail++;
        $display("FAIL %s step %0d: got hi=%h lo=%h sr=%b, want hi=%h lo=%h sr=%b",
                 ex.name, ex.idx, hi_o, lo_o, stall_req, ex.hi, ex.lo, ex.sr);
      end else n_pass++;
    end
  endtask

  task automatic test_priority();
    st.delete();
    st.push_back(mk(0, 0, 0, 0, 2'b10, 32'h11111111, 32'h0, 2'b00,
                    FWD ? 32'h11111111 : 32'hDEADBEEF, 32'hAAAA5555, 1'b0));
    st.push_back(mk(0, 0, 0, 0, 2'b10, 32'h22222222, 32'h0, 2'b10,
                    FWD ? 32'h22222222 : 32'hDEADBEEF, 32'hAAAA5555, !FWD));
    st.push_back(mk(0, 0, 0, 0, 2'b00, 32'h0, 32'h0, 2'b10,
                    FWD ? 32'h22222222 : 32'h11111111, 32'hAAAA5555, !FWD));
    st.push_back(mk(0, 0, 0, 0, 2'b00, 32'h0, 32'h0, 2'b10, 32'h22222222, 32'hAAAA5555, 1'b0));
    for (int i = 0; i < st.size(); i++) begin
      apply(st[i]);
      sb_q.push_back('{"priority", i, st[i].ehi, st[i].elo, st[i].esr});
      @(posedge clk); #1;
      ex = sb_q.pop_front();
      n_checks++;
      if ({hi_o, lo_o, stall_req} !== {ex.hi, ex.lo, ex.sr}) begin
        n_fail++;
        $display("FAIL %s step %0d: got hi=%h lo=%h sr=%b, want hi=%h lo=%h sr=%b",
                 ex.name, ex.idx, hi_o, lo_o, stall_req, ex.hi, ex.lo, ex.sr);
      end else n_pass++;
    end
  endtask

  task automatic test_flush();
    st.delete();
    // flush_m under stall kills M in place
    st.push_back(mk(0, 0, 0, 0, 2'b11, 32'h33333333, 32'h44444444, 2'b00,
                    FWD ? 32'h33333333 : 32'h22222222, FWD ? 32'h44444444 : 32'hAAAA5555, 1'b0));
    st.push_back(mk(0, 1, 0, 1, 2'b11, 32'h55555555, 32'h66666666, 2'b11, 32'h22222222, 32'hAAAA5555, 1'b0));
    for (int k = 0; k < 3; k++)
      st.push_back(mk(0, 0, 0, 0, 2'b00, 32'h0, 32'h0, 2'b11, 32'h22222222, 32'hAAAA5555, 1'b0));
    // flush_e drops the EX write
    st.push_back(mk(0, 0, 1, 0, 2'b11, 32'h77777777, 32'h88888888, 2'b11, 32'h22222222, 32'hAAAA5555, 1'b0));
    for (int k = 0; k < 2; k++)
      st.push_back(mk(0, 0, 0, 0, 2'b00, 32'h0, 32'h0, 2'b11, 32'h22222222, 32'hAAAA5555, 1'b0));
    // flush_m while advancing leaves a bubble in W
    st.push_back(mk(0, 0, 0, 0, 2'b11, 32'h99999999, 32'h9999AAAA, 2'b00,
                    FWD ? 32'h99999999 : 32'h22222222, FWD ? 32'h9999AAAA : 32'hAAAA5555, 1'b0));
    for (int k = 0; k < 3; k++)
      st.push_back(mk(0, 0, 0, (k == 0), 2'b00, 32'h0, 32'h0, 2'b11, 32'h22222222, 32'hAAAA5555, 1'b0));
    for (int i = 0; i < st.size(); i++) begin
      apply(st[i]);
      sb_q.push_back('{"flush", i, st[i].ehi, st[i].elo, st[i].esr});
      @(posedge clk); #1;
      ex = sb_q.pop_front();
      n_checks++;
      if ({hi_o, lo_o, stall_req} !== {ex.hi, ex.lo, ex.sr}) begin
        n_fail++;
        $display("FAIL %s step %0d: got hi=%h lo=%h sr=%b, want hi=%h lo=%h sr=%b",
                 ex.name, ex.idx, hi_o, lo_o, stall_req, ex.hi, ex.lo, ex.sr);
      end else n_pass++;
    end
  endtask

  task automatic test_stall_hold();
    st.delete();
    st.push_back(mk(0, 0, 0, 0, 2'b11, 32'hBBBBBBBB, 32'hCCCCCCCC, 2'b00,
                    FWD ? 32'hBBBBBBBB : 32'h22222222, FWD ? 32'hCCCCCCCC : 32'hAAAA5555, 1'b0));
    for (int k = 0; k < 5; k++)
      st.push_back(mk(0, (k != 0), (k == 2), 0, (k == 0) ? 2'b00 : 2'b11, 32'hDDDDDDDD, 32'hEEEEEEEE, 2'b11,
                      FWD ? 32'hBBBBBBBB : 32'h22222222, FWD ? 32'hCCCCCCCC : 32'hAAAA5555, !FWD));
    st.push_back(mk(0, 0, 0, 0, 2'b00, 32'h0, 32'h0, 2'b11, 32'hBBBBBBBB, 32'hCCCCCCCC, 1'b0));
    // reset during a stall clears everything
    st.push_back(mk(0, 0, 0, 0, 2'b11, 32'h12121212, 32'h34343434, 2'b00,
                    FWD ? 32'h12121212 : 32'hBBBBBBBB, FWD ? 32'h34343434 : 32'hCCCCCCCC, 1'b0));
    st.push_back(mk(0, 1, 0, 0, 2'b00, 32'h0, 32'h0, 2'b11,
                    FWD ? 32'h12121212 : 32'hBBBBBBBB, FWD ? 32'h34343434 : 32'hCCCCCCCC, !FWD));
    st.push_back(mk(1, 1, 0, 0, 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b11, 32'h0, 32'h0, 1'b0));
    st.push_back(mk(0, 0, 0, 0, 2'b00, 32'h0, 32'h0, 2'b11, 32'h0, 32'h0, 1'b0));
    for (int i = 0; i < st.size(); i++) begin
      apply(st[i]);
      sb_q.push_back('{"stall_hold", i, st[i].ehi, st[i].elo, st[i].esr});
      @(posedge clk); #1;
      ex = sb_q.pop_front();
      n_checks++;
      if ({hi_o, lo_o, stall_req} !== {ex.hi, ex.lo, ex.sr}) begin
        n_fail++;
        $display("FAIL %s step %0d: got hi=%h lo=%h sr=%b, want hi=%h lo=%h sr=%b",
                 ex.name, ex.idx, hi_o, lo_o, stall_req, ex.hi, ex.lo, ex.sr);
      end else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    st.delete();
    st.push_back(mk(0, 0, 0, 0, 2'b11, 32'h5A5A5A5A, 32'hA5A5A5A5, 2'b11,
                    FWD ? 32'h5A5A5A5A : 32'h0, FWD ? 32'hA5A5A5A5 : 32'h0, !FWD));
    st.push_back(mk(0, 0, 0, 0, 2'b01, 32'h0, 32'h0F0F0F0F, 2'b11,
                    FWD ? 32'h5A5A5A5A : 32'h0, FWD ? 32'h0F0F0F0F : 32'h0, !FWD));
    st.push_back(mk(0, 0, 0, 0, 2'b10, 32'hF0F0F0F0, 32'h0, 2'b10,
                    FWD ? 32'hF0F0F0F0 : 32'h5A5A5A5A, FWD ? 32'h0F0F0F0F : 32'hA5A5A5A5, !FWD));
    st.push_back(mk(0, 0, 0, 0, 2'b00, 32'h0, 32'h0, 2'b01,
                    FWD ? 32'hF0F0F0F0 : 32'h5A5A5A5A, 32'h0F0F0F0F, 1'b0));
    st.push_back(mk(0, 0, 0, 0, 2'b00, 32'h0, 32'h0, 2'b11, 32'hF0F0F0F0, 32'h0F0F0F0F, 1'b0));
    // same-cycle EX write must not be visible before the edge
    apply(st[0]);
    #1;
    n_checks++;
    if ({hi_o, lo_o, stall_req} !== {32'h0, 32'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL same_cycle_read: got hi=%h lo=%h sr=%b, want hi=00000000 lo=00000000 sr=0",
               hi_o, lo_o, stall_req);
    end else n_pass++;
    for (int i = 0; i < st.size(); i++) begin
      apply(st[i]);
      sb_q.push_back('{"back_to_back", i, st[i].ehi, st[i].elo, st[i].esr});
      @(posedge clk); #1;
      ex = sb_q.pop_front();
      n_checks++;
      if ({hi_o, lo_o, stall_req} !== {ex.hi, ex.lo, ex.sr}) begin
        n_fail++;
        $display("FAIL %s step %0d: got hi=%h lo=%h sr=%b, want hi=%h lo=%h sr=%b",
                 ex.name, ex.idx, hi_o, lo_o, stall_req, ex.hi, ex.lo, ex.sr);
      end else n_pass++;
    end
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_mult_commit();
    test_partial();
    test_priority();
    test_flush();
    test_stall_hold();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
